mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates the shared instruction/data memory between the instruction-fetch port (F) and the load/store port (D) of the multicycle MIPS datapath.
- Latches the winning request and drives the memory's A, WD, WE and RE pins for exactly one access cycle.
- Registers the read data and returns a one-cycle ack to the winning requester.
- Converts byte addresses to word indices and flags out-of-range accesses.

Parameters:
- DATA_W, 32, data width.
- ADDR_W, 32, byte-address width.
- DEPTH, 32, number of valid words; word index must be < DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- f_req  in  1  fetch request; held until f_ack.
- f_addr  in  ADDR_W  fetch byte address; stable while f_req=1.
- f_ack  out  1  one-cycle pulse; f_rdata valid in the same cycle.
- f_rdata  out  DATA_W  instruction word.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle pulse.
- d_rdata  out  DATA_W  load data.
- err  out  1  pulses with ack when the access was out of range.
- mem_A  out  32  word index to memory.
- mem_WD  out  DATA_W  write data to memory.
- mem_WE  out  1  memory write enable.
- mem_RE  out  1  1 = data array, 0 = instruction array.
- mem_RD  in  DATA_W  combinational read data from memory.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - reset is synchronous and active-high.
  - On reset: state=IDLE; f_ack, d_ack, err, mem_WE, mem_RE = 0; f_rdata, d_rdata, mem_A, mem_WD = 0; last_grant=D.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If neither req is set, stay in IDLE.
  - If exactly one req is set, grant it.
  - If both are set, grant the port opposite last_grant, so F wins the first tie after reset.
  - On grant: latch port id, word index = addr[ADDR_W-1:2], wdata, and we (forced 0 for F). Update last_grant. Go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_A = latched index.
  - mem_RE = 1 if the grant is D, else 0.
  - mem_WD = latched wdata.
  - mem_WE = latched we & in_range & ~reset.
  - At the clock edge: capture mem_RD into the granted port's rdata register, or 0 if out of range. Go to RESP.
  - in_range = (index < DEPTH).
- RESP (exactly 1 cycle):
  - Pulse the granted port's ack. err = ~in_range.
  - Store ack: rdata = 0. Load/fetch ack: rdata = captured word.
  - Arbitration runs as in IDLE, excluding the port being acked (its req is still high this cycle). Any other pending req goes straight to ACCESS with no IDLE bubble; otherwise go to IDLE.
- Timing:
  - Latency: req seen in IDLE at edge N means the access is at N+1 and ack is high during cycle N+2.
  - Back-to-back throughput is one access per 2 cycles.
- Outside ACCESS: mem_WE=0, mem_RE=0, mem_A and mem_WD hold their last value. Non-granted ack outputs stay 0.
- Out of range:
  - No write occurs.
  - rdata = 0, err=1 with the ack.
  - The block never drives mem_A >= DEPTH while mem_WE=1.
- A misaligned address (addr[1:0] != 0) is truncated; no error is flagged.
- Req dropped after grant: the transaction completes and the ack still pulses. The requester must ignore it.
- Both acks are never high in the same cycle.
- Reset asserted in ACCESS: mem_WE is gated low in that cycle, so no write commits. The FSM returns to IDLE and no ack is issued.
- Reset asserted in RESP: the ack is suppressed from the next cycle onward.

Test Plan:
- Reset, then f_req=1, f_addr=0x8 → mem_A=2 and mem_RE=0 in cycle 2; f_ack=1 with f_rdata = InstrMem[2] in cycle 3; err=0.
- d_req=1, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF → mem_WE=1, mem_A=4 for one cycle. Then a load from 0x10 returns d_rdata=0xDEADBEEF with d_ack.
- f_req and d_req held together from reset → grants go F, D, F, D alternately. Acks arrive at 2-cycle spacing and are never simultaneous.
- d_req store to d_addr=0x80 (index 32, DEPTH=32) → mem_WE stays 0, d_ack=1 with err=1, d_rdata=0. The memory contents are unchanged on readback.
- Store granted, then reset=1 during ACCESS → mem_WE=0 that cycle, no d_ack, and the target word keeps its old value. After reset, state is IDLE with all outputs 0.
- f_req dropped in the cycle after grant → f_ack still pulses once. A pending d_req is then granted directly from RESP, with ack two cycles after the f_ack.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/load-store request ports and shared memory pins
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    // Instruction-fetch port
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_ack;
    logic [DATA_W-1:0] f_rdata;

    // Load/store port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    // Shared status and memory pins
    logic              err;
    logic [31:0]       mem_A;
    logic [DATA_W-1:0] mem_WD;
    logic              mem_WE;
    logic              mem_RE;
    logic [DATA_W-1:0] mem_RD;

    // Arbiter side
    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_RD,
        output f_ack, f_rdata, d_ack, d_rdata, err,
               mem_A, mem_WD, mem_WE, mem_RE
    );

    // Requester and memory side
    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_RD,
        input  f_ack, f_rdata, d_ack, d_rdata, err,
               mem_A, mem_WD, mem_WE, mem_RE
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch vs load/store arbiter for the shared multicycle MIPS memory
module mem_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_t            state;
    logic              grant_q;
    logic              last_grant;
    logic              store_q;
    logic              we_q;
    logic              in_range_q;
    logic              f_ack_q;
    logic              d_ack_q;
    logic              err_q;
    logic              mem_re_q;
    logic [31:0]       mem_a_q;
    logic [DATA_W-1:0] mem_wd_q;
    logic [DATA_W-1:0] f_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic              f_cand;
    logic              d_cand;
    logic              pick;
    logic [ADDR_W-1:0] pick_addr;
    logic [ADDR_W-1:0] pick_word;
    logic              pick_in_range;

    // Arbitration: in RESP the port being acked still holds its req, so it is masked out
    always_comb begin
        f_cand = bus.f_req;
        d_cand = bus.d_req;
        if (state == RESP) begin
            if (grant_q == PORT_D) begin
                d_cand = 1'b0;
            end else begin
                f_cand = 1'b0;
            end
        end
        if (f_cand && d_cand) begin
            pick = ~last_grant;
        end else begin
            pick = d_cand;
        end
        pick_addr     = (pick == PORT_D) ? bus.d_addr : bus.f_addr;
        pick_word     = pick_addr >> 2;
        pick_in_range = (pick_word < ADDR_W'(DEPTH));
    end

    // Request FSM with all handshake and memory pins registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant_q    <= PORT_F;
            last_grant <= PORT_D;
            store_q    <= 1'b0;
            we_q       <= 1'b0;
            in_range_q <= 1'b0;
            f_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            err_q      <= 1'b0;
            mem_re_q   <= 1'b0;
            mem_a_q    <= '0;
            mem_wd_q   <= '0;
            f_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            f_ack_q  <= 1'b0;
            d_ack_q  <= 1'b0;
            err_q    <= 1'b0;
            mem_re_q <= 1'b0;
            we_q     <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (f_cand || d_cand) begin
                        grant_q    <= pick;
                        last_grant <= pick;
                        store_q    <= (pick == PORT_D) && bus.d_we;
                        we_q       <= (pick == PORT_D) && bus.d_we && pick_in_range;
                        in_range_q <= pick_in_range;
                        mem_re_q   <= (pick == PORT_D);
                        mem_a_q    <= 32'(pick_word);
                        if (pick == PORT_D) begin
                            mem_wd_q <= bus.d_wdata;
                        end
                        state <= ACCESS;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    err_q <= ~in_range_q;
                    if (grant_q == PORT_D) begin
                        d_ack_q   <= 1'b1;
                        d_rdata_q <= (store_q || !in_range_q) ? '0 : bus.mem_RD;
                    end else begin
                        f_ack_q   <= 1'b1;
                        f_rdata_q <= in_range_q ? bus.mem_RD : '0;
                    end
                    state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A reset arriving mid-access must not let the write commit on that edge
    assign bus.mem_WE  = we_q & ~reset;
    assign bus.mem_RE  = mem_re_q;
    assign bus.mem_A   = mem_a_q;
    assign bus.mem_WD  = mem_wd_q;
    assign bus.f_ack   = f_ack_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.err     = err_q;
    assign bus.f_rdata = f_rdata_q;
    assign bus.d_rdata = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int DEPTH = 32;

    logic clk;
    logic reset;
    logic init_mem;
    int   n_tests;
    int   n_fail;

    logic [31:0] dmem [DEPTH];
    logic [31:0] ref_dmem [DEPTH];

    mem_port_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    mem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem_val(input logic [31:0] idx);
        return 32'hC0DE_0000 | {16'h0, idx[15:0]};
    endfunction

    function automatic logic [31:0] dmem_init(input int idx);
        return 32'hDA7A_0000 | 32'(idx);
    endfunction

    // Memory model: combinational read, words outside DEPTH read back as junk
    assign bus.mem_RD = (bus.mem_A >= DEPTH) ? 32'hBAD0_BAD0 :
                        (bus.mem_RE ? dmem[bus.mem_A[4:0]] : imem_val(bus.mem_A));

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < DEPTH; i++) dmem[i] <= dmem_init(i);
        end else if (bus.mem_WE) begin
            dmem[bus.mem_A[4:0]] <= bus.mem_WD;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic init);
        reset = 1'b1;
        init_mem = init;
        bus.f_req = 1'b0;
        bus.d_req = 1'b0;
        step();
        step();
        reset = 1'b0;
        init_mem = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return $urandom;
        return (32'($urandom_range(0, 37)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    logic        f_pend, d_pend, d_we_r;
    int          f_wait, d_wait, f_gap, d_gap;
    logic [31:0] f_a, d_a, d_wd, idx, exp_rd;
    logic        inr;

    initial begin
        n_tests = 0;
        n_fail = 0;
        reset = 1'b1;
        init_mem = 1'b1;
        bus.f_req = 1'b0; bus.f_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        step();
        step();
        // Reset state
        check("rst_f_ack", bus.f_ack, 0);
        check("rst_d_ack", bus.d_ack, 0);
        check("rst_err", bus.err, 0);
        check("rst_we_re", {bus.mem_WE, bus.mem_RE}, 0);
        check("rst_mem_A", bus.mem_A, 0);
        check("rst_rdata", {bus.f_rdata, bus.d_rdata}, 0);
        reset = 1'b0;
        init_mem = 1'b0;

        // Single fetch from 0x8
        bus.f_req = 1'b1; bus.f_addr = 32'h8;
        step();
        check("f_mem_A", bus.mem_A, 2);
        check("f_mem_RE", bus.mem_RE, 0);
        check("f_ack_early", bus.f_ack, 0);
        step();
        check("f_ack", bus.f_ack, 1);
        check("f_rdata", bus.f_rdata, imem_val(2));
        check("f_err", bus.err, 0);
        check("f_d_ack", bus.d_ack, 0);
        bus.f_req = 1'b0;
        step();
        check("f_ack_once", bus.f_ack, 0);

        // Store then load at 0x10
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h10; bus.d_wdata = 32'hDEAD_BEEF;
        step();
        check("st_mem_WE", bus.mem_WE, 1);
        check("st_mem_A", bus.mem_A, 4);
        check("st_mem_WD", bus.mem_WD, 32'hDEAD_BEEF);
        step();
        check("st_ack", bus.d_ack, 1);
        check("st_rdata", bus.d_rdata, 0);
        check("st_we_off", bus.mem_WE, 0);
        bus.d_req = 1'b0;
        step();
        bus.d_req = 1'b1; bus.d_we = 1'b0;
        step();
        step();
        check("ld_ack", bus.d_ack, 1);
        check("ld_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        bus.d_req = 1'b0;
        step();

        // Both held from reset: F, D, F, D at 2-cycle spacing
        do_reset(1'b0);
        bus.f_req = 1'b1; bus.f_addr = 32'h4;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("alt_f_ack_%0d", i), bus.f_ack, (i % 4 == 2) ? 1 : 0);
            check($sformatf("alt_d_ack_%0d", i), bus.d_ack, (i % 4 == 0) ? 1 : 0);
        end
        bus.f_req = 1'b0; bus.d_req = 1'b0;
        step();

        // Out-of-range store at 0x80
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h80; bus.d_wdata = 32'h1234_5678;
        step();
        check("oor_mem_WE", bus.mem_WE, 0);
        step();
        check("oor_ack", bus.d_ack, 1);
        check("oor_err", bus.err, 1);
        check("oor_rdata", bus.d_rdata, 0);
        bus.d_req = 1'b0;
        step();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0;
        step();
        step();
        check("oor_readback", bus.d_rdata, dmem_init(0));
        check("oor_rb_err", bus.err, 0);
        bus.d_req = 1'b0;
        step();

        // Reset during the ACCESS cycle of a store
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h14; bus.d_wdata = 32'hAAAA_AAAA;
        step();
        reset = 1'b1;
        bus.d_req = 1'b0;
        #1;
        check("rstacc_mem_WE", bus.mem_WE, 0);
        step();
        check("rstacc_acks", {bus.f_ack, bus.d_ack, bus.err}, 0);
        check("rstacc_we_re", {bus.mem_WE, bus.mem_RE}, 0);
        check("rstacc_A_WD", {bus.mem_A, bus.mem_WD}, 0);
        check("rstacc_rdata", {bus.f_rdata, bus.d_rdata}, 0);
        reset = 1'b0;
        step();
        check("rstacc_no_ack", bus.d_ack, 0);
        check("rstacc_word", dmem[5], dmem_init(5));

        // Fetch dropped after grant, pending load granted straight from RESP
        bus.f_req = 1'b1; bus.f_addr = 32'hC;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
        step();
        check("drop_f_A", bus.mem_A, 3);
        check("drop_f_RE", bus.mem_RE, 0);
        bus.f_req = 1'b0;
        step();
        check("drop_f_ack", bus.f_ack, 1);
        check("drop_f_rdata", bus.f_rdata, imem_val(3));
        step();
        check("drop_d_RE", bus.mem_RE, 1);
        check("drop_d_A", bus.mem_A, 4);
        check("drop_f_ack_off", bus.f_ack, 0);
        step();
        check("drop_d_ack", bus.d_ack, 1);
        check("drop_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        bus.d_req = 1'b0;
        step();

        // Randomized traffic against a transaction-level memory scoreboard
        do_reset(1'b1);
        for (int i = 0; i < DEPTH; i++) ref_dmem[i] = dmem_init(i);
        f_pend = 1'b0; d_pend = 1'b0; d_we_r = 1'b0;
        f_wait = 0; d_wait = 0; f_gap = 0; d_gap = 0;
        f_a = '0; d_a = '0; d_wd = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            check("rnd_ack_excl", bus.f_ack & bus.d_ack, 0);
            check("rnd_we_range", bus.mem_WE && (bus.mem_A >= DEPTH), 0);
            if (bus.f_ack) begin
                check("rnd_f_ack_pend", f_pend, 1);
                idx = f_a >> 2;
                inr = (idx < DEPTH);
                check("rnd_f_rdata", bus.f_rdata, inr ? imem_val(idx) : 32'h0);
                check("rnd_f_err", bus.err, !inr);
                f_pend = 1'b0;
                f_gap = $urandom_range(1, 4);
            end else if (f_pend) begin
                f_wait++;
                if (f_wait > 8) begin
                    check("rnd_f_timeout", f_wait, 8);
                    f_pend = 1'b0;
                end
            end else if (f_gap > 0) begin
                f_gap--;
            end else if ($urandom_range(0, 1) == 1) begin
                f_pend = 1'b1; f_wait = 0; f_a = rand_addr();
            end
            if (bus.d_ack) begin
                check("rnd_d_ack_pend", d_pend, 1);
                idx = d_a >> 2;
                inr = (idx < DEPTH);
                exp_rd = (d_we_r || !inr) ? 32'h0 : ref_dmem[idx[4:0]];
                if (d_we_r && inr) ref_dmem[idx[4:0]] = d_wd;
                check("rnd_d_rdata", bus.d_rdata, exp_rd);
                check("rnd_d_err", bus.err, !inr);
                d_pend = 1'b0;
                d_gap = $urandom_range(1, 4);
            end else if (d_pend) begin
                d_wait++;
                if (d_wait > 8) begin
                    check("rnd_d_timeout", d_wait, 8);
                    d_pend = 1'b0;
                end
            end else if (d_gap > 0) begin
                d_gap--;
            end else if ($urandom_range(0, 1) == 1) begin
                d_pend = 1'b1; d_wait = 0; d_a = rand_addr();
                d_we_r = ($urandom_range(0, 2) == 0); d_wd = $urandom;
            end
            bus.f_req = f_pend; bus.f_addr = f_a;
            bus.d_req = d_pend; bus.d_addr = d_a; bus.d_we = d_we_r; bus.d_wdata = d_wd;
        end
        bus.f_req = 1'b0; bus.d_req = 1'b0;
        step();
        step();
        for (int i = 0; i < DEPTH; i++) check($sformatf("final_mem_%0d", i), dmem[i], ref_dmem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
